// File: rtl/fxp_mac_pkg.sv
// Shared types and constants for the saturating fixed-point MAC engine.
// Saturation bounds are symmetric so that negating a clamped value never overflows.
package fxp_mac_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Cycles the FSM waits after the last beat so that beat can reach the accumulator.
    localparam int unsigned DRAIN_CYCLES = 3;

    function automatic logic signed [63:0] sat_max(input int unsigned dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned dw);
        return -sat_max(dw);
    endfunction

    function automatic logic signed [63:0] rnd_const(input int unsigned frac);
        return 64'sd1 <<< (frac - 1);
    endfunction

endpackage

// File: rtl/fxp_mul_rnd_sat.sv
// Stages S2-S3: full-width signed multiply, round half-up, symmetric saturation.
// flush invalidates both stages on the same edge it is seen.
module fxp_mul_rnd_sat
    import fxp_mac_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned FRAC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    output logic [DW-1:0] out_res,
    output logic          out_sat
);

    localparam int unsigned PW = 2 * DW;
    localparam logic signed [PW-1:0] P_MAX = PW'(sat_max(DW));
    localparam logic signed [PW-1:0] P_MIN = PW'(sat_min(DW));
    localparam logic signed [PW-1:0] P_RND = PW'(rnd_const(FRAC));

    logic signed [PW-1:0] prod_d, prod_q;
    logic signed [PW-1:0] rnd;
    logic                 v2_d, v2_q, v3_d, v3_q;
    logic                 sat3_d, sat3_q;
    logic [DW-1:0]        res3_d, res3_q;

    always_comb begin
        prod_d = PW'($signed(in_a)) * PW'($signed(in_b));
        v2_d   = flush ? 1'b0 : in_valid;

        rnd    = (prod_q + P_RND) >>> FRAC;
        sat3_d = 1'b0;
        res3_d = rnd[DW-1:0];
        // Exact -2^(DW-1) falls below P_MIN and is clamped like any other overflow.
        if (rnd > P_MAX) begin
            res3_d = P_MAX[DW-1:0];
            sat3_d = 1'b1;
        end else if (rnd < P_MIN) begin
            res3_d = P_MIN[DW-1:0];
            sat3_d = 1'b1;
        end
        v3_d = flush ? 1'b0 : v2_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_q <= '0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            sat3_q <= 1'b0;
            res3_q <= '0;
        end else begin
            prod_q <= prod_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            sat3_q <= sat3_d;
            res3_q <= res3_d;
        end
    end

    assign out_valid = v3_q;
    assign out_res   = res3_q;
    assign out_sat   = sat3_q;

endmodule

// File: rtl/fxp_mac_pipe.sv
// Framed, pipelined, saturating fixed-point multiply-accumulate with valid/ready handshakes.
// One result per frame; the accumulator, sticky flag and beat count are the output registers.
module fxp_mac_pipe
    import fxp_mac_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_result,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_beats
);

    localparam logic signed [DW:0]    SUM_MAX = (DW + 1)'(sat_max(DW));
    localparam logic signed [DW:0]    SUM_MIN = (DW + 1)'(sat_min(DW));
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;

    state_e            state_d, state_q;
    logic [1:0]        drain_d, drain_q;
    logic              in_ready_d, in_ready_q;
    logic              out_valid_d, out_valid_q;
    logic              s1_valid_d, s1_valid_q;
    logic [DW-1:0]     s1_a_d, s1_a_q, s1_b_d, s1_b_q;
    logic [DW-1:0]     acc_d, acc_q;
    logic              sat_d, sat_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              s3_valid, s3_sat;
    logic [DW-1:0]     s3_res;
    logic signed [DW:0] sum;
    logic              accept;

    assign accept = in_valid && in_ready_q;

    fxp_mul_rnd_sat #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .flush     (clear),
        .in_valid  (s1_valid_q),
        .in_a      (s1_a_q),
        .in_b      (s1_b_q),
        .out_valid (s3_valid),
        .out_res   (s3_res),
        .out_sat   (s3_sat)
    );

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        cnt_d      = cnt_q;
        s1_valid_d = accept;
        s1_a_d     = accept ? in_a : s1_a_q;
        s1_b_d     = accept ? in_b : s1_b_q;

        // S4: saturating accumulate; a clamped accumulator keeps going from the clamp.
        sum = $signed({acc_q[DW-1], acc_q}) + $signed({s3_res[DW-1], s3_res});
        if (s3_valid) begin
            if (sum > SUM_MAX) begin
                acc_d = SUM_MAX[DW-1:0];
                sat_d = 1'b1;
            end else if (sum < SUM_MIN) begin
                acc_d = SUM_MIN[DW-1:0];
                sat_d = 1'b1;
            end else begin
                acc_d = sum[DW-1:0];
            end
            if (s3_sat) begin
                sat_d = 1'b1;
            end
        end

        case (state_q)
            RUN: begin
                if (accept) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = DRAIN;
                        drain_d = 2'(DRAIN_CYCLES);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = HOLD;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (clear) begin
            s1_valid_d = 1'b0;
            acc_d      = '0;
            sat_d      = 1'b0;
            cnt_d      = '0;
            drain_d    = 2'd0;
            state_d    = RUN;
        end

        in_ready_d  = (state_d == RUN);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            drain_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = acc_q;
    assign out_sat    = sat_q;
    assign out_beats  = cnt_q;

endmodule

// File: tb/tb_fxp_mac_pipe.sv
// Directed, table-driven bench for fxp_mac_pipe at DW=16, FRAC=8, CNT_W=8.
// Expected values are hand-computed Q8.8 results.
module tb_fxp_mac_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_sat;
    logic [7:0]  out_beats;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fxp_mac_pipe #(
        .DW    (16),
        .FRAC  (8),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sat    (out_sat),
        .out_beats  (out_beats)
    );

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [15:0]      res;
        logic             sat;
        logic [7:0]       beats;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] n,
                                input logic [15:0] a0, input logic [15:0] b0,
                                input logic [15:0] a1, input logic [15:0] b1,
                                input logic [15:0] a2, input logic [15:0] b2,
                                input logic [15:0] a3, input logic [15:0] b3,
                                input logic [15:0] res, input logic sat,
                                input logic [7:0] beats);
        vec_t v;
        v.n = n;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.res = res;
        v.sat = sat;
        v.beats = beats;
        return v;
    endfunction

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " valid_after_hs"}, 32'(out_valid), 32'd0);
        chk({tag, " ready_after_hs"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_frame(input vec_t v, input string tag, input bit hs);
        int lat;
        for (int i = 0; i < int'(v.n); i++) begin
            @(negedge clk);
            chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_a     = v.a[i];
            in_b     = v.b[i];
            in_last  = (i == int'(v.n) - 1);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " result"}, 32'(out_result), 32'(v.res));
        chk({tag, " sat"}, 32'(out_sat), 32'(v.sat));
        chk({tag, " beats"}, 32'(out_beats), 32'(v.beats));
        chk({tag, " ready_in_hold"}, 32'(in_ready), 32'd0);
        if (hs) handshake(tag);
    endtask

    initial begin
        vec_t v;
        vecs[0] = mk(3'd2, 16'h0180, 16'h0200, 16'h0100, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0,
                     16'h0400, 1'b0, 8'd2);
        vecs[1] = mk(3'd1, 16'h0001, 16'h0080, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                     16'h0001, 1'b0, 8'd1);
        vecs[2] = mk(3'd1, 16'hFFFF, 16'h0080, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                     16'h0000, 1'b0, 8'd1);
        vecs[3] = mk(3'd1, 16'hFFFF, 16'h0081, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                     16'hFFFF, 1'b0, 8'd1);
        vecs[4] = mk(3'd1, 16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                     16'h7FFF, 1'b1, 8'd1);
        vecs[5] = mk(3'd1, 16'h8000, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                     16'h8001, 1'b1, 8'd1);
        vecs[6] = mk(3'd1, 16'h8000, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                     16'h8001, 1'b1, 8'd1);
        vecs[7] = mk(3'd4, 16'h4000, 16'h0100, 16'h4000, 16'h0100, 16'h4000, 16'h0100,
                     16'hC000, 16'h0100, 16'h3FFF, 1'b1, 8'd4);
        // -2.0*1.5 + 0.5*0.5 = -2.75
        vecs[8] = mk(3'd2, 16'hFE00, 16'h0180, 16'h0080, 16'h0080, 16'h0, 16'h0, 16'h0, 16'h0,
                     16'hFD40, 1'b0, 8'd2);
        // 1.5 LSB rounds up to 2
        vecs[9] = mk(3'd1, 16'h0001, 16'h0180, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                     16'h0002, 1'b0, 8'd1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_result", 32'(out_result), 32'd0);
        chk("reset out_sat", 32'(out_sat), 32'd0);
        chk("reset out_beats", 32'(out_beats), 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_frame(vecs[i], $sformatf("vec%0d", i), 1'b1);
        end

        // Backpressure: result held, stray beats ignored and not counted.
        v = mk(3'd1, 16'h0200, 16'h0300, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
               16'h0600, 1'b0, 8'd1);
        do_frame(v, "bp", 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 16'h7FFF;
            in_b     = 16'h7FFF;
            in_last  = k[0];
            @(posedge clk);
            #1;
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold result", 32'(out_result), 32'h0600);
            chk("bp hold ready", 32'(in_ready), 32'd0);
            chk("bp hold beats", 32'(out_beats), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake("bp");
        v = mk(3'd1, 16'h0100, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
               16'h0100, 1'b0, 8'd1);
        do_frame(v, "bp next", 1'b1);

        // Clear after two beats; a beat presented with clear is dropped.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = (i == 2) ? 16'h7FFF : 16'h0100;
            in_b     = (i == 2) ? 16'h7FFF : 16'h0100;
            clear    = (i == 2);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("clear out_valid", 32'(out_valid), 32'd0);
        chk("clear in_ready", 32'(in_ready), 32'd1);
        chk("clear out_result", 32'(out_result), 32'd0);
        chk("clear out_sat", 32'(out_sat), 32'd0);
        chk("clear out_beats", 32'(out_beats), 32'd0);
        do_frame(v, "after clear", 1'b1);

        // clear in HOLD drops the unconsumed result.
        do_frame(vecs[4], "clr hold", 1'b0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr hold out_valid", 32'(out_valid), 32'd0);
        chk("clr hold in_ready", 32'(in_ready), 32'd1);
        chk("clr hold out_sat", 32'(out_sat), 32'd0);

        // Reset in HOLD.
        do_frame(vecs[0], "rst hold", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst hold out_valid", 32'(out_valid), 32'd0);
        chk("rst hold in_ready", 32'(in_ready), 32'd1);
        chk("rst hold out_result", 32'(out_result), 32'd0);
        chk("rst hold out_beats", 32'(out_beats), 32'd0);
        do_frame(vecs[8], "after rst", 1'b1);

        // Beat counter saturates at 255 on a 260-beat zero frame.
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 16'h0000;
            in_b     = 16'h0000;
            in_last  = (i == 259);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("cnt sat valid", 32'(out_valid), 32'd1);
        chk("cnt sat beats", 32'(out_beats), 32'd255);
        chk("cnt sat result", 32'(out_result), 32'd0);
        handshake("cnt sat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fxp_mac_pipe.md
Name: fxp_mac_pipe

Overview:
- Parametrised, pipelined, saturating fixed-point multiply-accumulate engine for signed Q-format operands.
- Accumulates a framed stream of A×B products into one result per frame, marked by in_last.
- Adds valid/ready handshakes, configurable width and fraction, a sticky saturation flag, a beat count and a synchronous clear.
- Sits between an operand streamer and a result consumer in the datapath.

Parameters:
- DW, 16, operand, product-after-rounding, accumulator and result width, in bits (two's complement).
- FRAC, 8, fraction bits of operands and result; legal range 1..DW-1.
- CNT_W, 8, width of the per-frame beat counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- clear  in  1  synchronous abort: flushes the pipeline and discards the current frame.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine can accept a beat.
- in_a  in  DW  signed operand A.
- in_b  in  DW  signed operand B.
- in_last  in  1  final beat of the frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DW  saturated frame sum.
- out_sat  out  1  sticky flag: any product or accumulation in the frame saturated.
- out_beats  out  CNT_W  number of beats accepted in the frame.

Behaviour:
- Reset (rst==0 at an edge): all pipeline registers, accumulator and counter are 0; FSM goes to RUN.
  - Outputs after reset: in_ready=1, out_valid=0, out_result=0, out_sat=0, out_beats=0.
  - Reset overrides clear. Reset mid-frame discards everything.
- Beat accept: a beat is accepted when in_valid && in_ready at an edge.
- Pipeline, fixed 4 stages with no stalls inside:
  - S1: register a, b, last, valid.
  - S2: full 2*DW signed product.
  - S3: round half-up, then saturate.
    - Round: add 1<<(FRAC-1), then arithmetic shift right by FRAC, so -0.5 LSB rounds to 0.
    - Saturate symmetrically to [-(2^(DW-1)-1), +(2^(DW-1)-1)]; for DW=16 that is 0x8001..0x7FFF.
    - An exact -2^(DW-1) result is also clamped to the minimum and sets sat.
  - S4: accumulator <= sat_add(acc, rounded).
    - Overflow of two same-sign operands clamps to the max/min above and sets sat.
    - A saturated accumulator continues from the clamped value.
- Beat counter: increments per accepted beat and saturates at 2^CNT_W-1 (no wrap).
- FSM states: RUN, DRAIN, HOLD.
  - RUN: in_ready=1. Accepting a beat with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0. A 3-cycle down-counter lets the last beat reach S4; then go to HOLD.
  - HOLD: out_valid=1; out_result, out_sat and out_beats are registered and stable.
    - On an out_ready handshake: clear acc, sat and counter, then go to RUN.
    - in_ready returns to 1 the cycle after the handshake edge.
- Latency: in_last accepted at edge N → out_valid=1 after edge N+4. Minimum frame period is beats+5 cycles.
- in_valid in DRAIN/HOLD is ignored; no beat is lost because in_ready=0 in those states.
- Single-beat frame (in_last on the first beat) is legal; out_beats=1.
- clear=1 at an edge:
  - Invalidates S1–S3, zeroes acc, sat and counter, drops out_valid, and goes to RUN.
  - Any beat presented on that edge is discarded.
  - clear in HOLD discards the unconsumed result.
- out_valid stays high until the handshake. out_result and the other outputs hold; they do not depend on out_ready.

Decomposition:
- Package fxp_mac_pkg holds:
  - state enum {RUN, DRAIN, HOLD};
  - DRAIN_CYCLES=3;
  - functions sat_max(DW), sat_min(DW), rnd_const(FRAC).
- One sub-module, fxp_mul_rnd_sat: stages S2–S3 (multiply, round, symmetric saturate, sat bit out).
- FSM, counter and accumulator stay in the top level.

Test Plan (DW=16, FRAC=8):
- Basic frame: beats (0x0180,0x0200) then (0x0100,0x0100, last).
  - Result 0x0300+0x0100 → out_result=0x0400, out_sat=0, out_beats=2.
  - out_valid rises 4 edges after the last beat is accepted.
- Rounding: single beat (0x0001,0x0080) → 0x0001. Single beat (0xFFFF,0x0080) → 0x0000. Single beat (0xFFFF,0x0081) → 0xFFFF.
- Product saturation:
  - (0x7FFF,0x7FFF) → 0x7FFF, sat=1.
  - (0x8000,0x7FFF) → 0x8001, sat=1.
  - (0x8000,0x0100) → 0x8001, sat=1.
- Accumulator saturation: 3 beats (0x4000,0x0100) then (0xC000,0x0100, last) → 0x3FFF, sat=1, beats=4.
- Backpressure: hold out_ready=0 for 10 cycles.
  - out_valid and out_result stay stable; in_ready=0 throughout.
  - Beats driven meanwhile are not counted.
  - After the handshake, the next frame's result is correct.
- Clear/reset mid-frame:
  - clear after 2 beats, then a frame of (0x0100,0x0100, last) → 0x0100, beats=1.
  - rst=0 in HOLD → out_valid=0 and in_ready=1 on the next cycle.
